// File: rtl/isp_loader_pkg.sv
// rtl/isp_loader_pkg.sv - shared state encoding and constants for the ISP loader
package isp_loader_pkg;

    localparam int COUNT_WIDTH = 16;
    localparam logic [7:0] CHK_INIT = 8'h00;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COUNT_HI = 3'd1,
        DATA     = 3'd2,
        CHECK    = 3'd3,
        START    = 3'd4,
        DONE     = 3'd5,
        ERROR    = 3'd6
    } state_t;

endpackage

// File: rtl/isp_word_assembler.sv
// rtl/isp_word_assembler.sv - little-endian byte-to-word assembly and write strobe
module isp_word_assembler #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    take,
    input  logic [7:0]              byte_data,
    input  logic [ADDRESS_BITS-1:0] word_index,
    output logic                    word_complete,
    output logic                    isp_write,
    output logic [DATA_WIDTH-1:0]   isp_data,
    output logic [ADDRESS_BITS-1:0] isp_address
);

    logic [1:0]  byte_count;
    logic [23:0] shift_q;

    // The fourth byte of a word completes it in the same cycle it is taken.
    assign word_complete = take && (byte_count == 2'd3);

    // Collect the three low bytes, then publish the full word with a one-cycle strobe.
    always_ff @(posedge clock) begin
        if (!reset) begin
            byte_count  <= 2'd0;
            shift_q     <= 24'h0;
            isp_write   <= 1'b0;
            isp_data    <= '0;
            isp_address <= '0;
        end else begin
            isp_write <= 1'b0;
            if (clear) begin
                byte_count <= 2'd0;
            end else if (take) begin
                case (byte_count)
                    2'd0: shift_q[7:0]   <= byte_data;
                    2'd1: shift_q[15:8]  <= byte_data;
                    2'd2: shift_q[23:16] <= byte_data;
                    default: begin
                        isp_data    <= {byte_data, shift_q};
                        isp_address <= word_index;
                        isp_write   <= 1'b1;
                    end
                endcase
                byte_count <= byte_count + 2'd1;
            end
        end
    end

endmodule

// File: rtl/isp_loader.sv
// rtl/isp_loader.sv - framed byte-stream program loader driving the ISP port
module isp_loader
    import isp_loader_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 10,
    parameter logic [ADDRESS_BITS-1:0] BOOT_ADDRESS = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    output logic                    in_ready,
    output logic [ADDRESS_BITS-1:0] isp_address,
    output logic [DATA_WIDTH-1:0]   isp_data,
    output logic                    isp_write,
    output logic                    core_hold,
    output logic                    start,
    output logic [ADDRESS_BITS-1:0] prog_address,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [ADDRESS_BITS:0]   words_loaded
);

    localparam logic [COUNT_WIDTH:0] MAX_WORDS = (COUNT_WIDTH+1)'(2**ADDRESS_BITS);

    state_t                 state_q;
    state_t                 state_d;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_n;
    logic [7:0]             chk_q;
    logic                   accept;
    logic                   frame_start;
    logic                   take;
    logic                   word_complete;
    logic                   last_word;

    assign accept      = in_valid && in_ready;
    assign frame_start = accept && (state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign take        = accept && (state_q == DATA);
    assign count_n     = {in_data, count_q[7:0]};
    assign last_word   = word_complete &&
                         ((COUNT_WIDTH'(words_loaded) + COUNT_WIDTH'(1)) == count_q);

    // Status outputs are pure decodes of the state; DONE and ERROR persist until the next frame.
    assign in_ready     = (state_q != START);
    assign core_hold    = !(state_q == START || state_q == DONE);
    assign start        = (state_q == START);
    assign prog_address = BOOT_ADDRESS;
    assign busy         = (state_q == COUNT_HI || state_q == DATA ||
                           state_q == CHECK || state_q == START);
    assign done         = (state_q == DONE);
    assign error        = (state_q == ERROR);

    isp_word_assembler #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_BITS (ADDRESS_BITS)
    ) u_assembler (
        .clock         (clock),
        .reset         (reset),
        .clear         (frame_start),
        .take          (take),
        .byte_data     (in_data),
        .word_index    (words_loaded[ADDRESS_BITS-1:0]),
        .word_complete (word_complete),
        .isp_write     (isp_write),
        .isp_data      (isp_data),
        .isp_address   (isp_address)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame sequencing: count bytes, data words, checksum, then start or error.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERROR: if (accept) state_d = COUNT_HI;
            COUNT_HI: begin
                if (accept) begin
                    if ({1'b0, count_n} > MAX_WORDS) state_d = ERROR;
                    else if (count_n == '0)          state_d = CHECK;
                    else                             state_d = DATA;
                end
            end
            DATA:    if (last_word) state_d = CHECK;
            CHECK:   if (accept) state_d = (in_data == chk_q) ? START : ERROR;
            START:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Word count, running checksum and the progress counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q      <= '0;
            chk_q        <= CHK_INIT;
            words_loaded <= '0;
        end else if (frame_start) begin
            count_q      <= {8'h00, in_data};
            chk_q        <= CHK_INIT ^ in_data;
            words_loaded <= '0;
        end else if (accept && state_q == COUNT_HI) begin
            count_q <= count_n;
            chk_q   <= chk_q ^ in_data;
        end else if (take) begin
            chk_q <= chk_q ^ in_data;
            if (word_complete) words_loaded <= words_loaded + 1'b1;
        end
    end

endmodule

// File: tb/tb_isp_loader.sv
// tb/tb_isp_loader.sv - scoreboard bench for the ISP loader
module tb_isp_loader;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [9:0]  isp_address;
    logic [31:0] isp_data;
    logic        isp_write;
    logic        core_hold;
    logic        start;
    logic [9:0]  prog_address;
    logic        busy;
    logic        done;
    logic        error;
    logic [10:0] words_loaded;

    int n_checks = 0;
    int n_errors = 0;
    int start_count = 0;
    int write_count = 0;

    logic [41:0] exp_q[$];
    logic [31:0] frame_words[0:1023];

    isp_loader dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .isp_address  (isp_address),
        .isp_data     (isp_data),
        .isp_write    (isp_write),
        .core_hold    (core_hold),
        .start        (start),
        .prog_address (prog_address),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard: every write must match the next queued expectation; start must carry the boot address.
    always @(negedge clock) begin
        if (reset) begin
            if (isp_write) begin
                logic [41:0] e;
                write_count++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_write addr=%0d data=%h", isp_address, isp_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({isp_address, isp_data} !== e) begin
                        n_errors++;
                        $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                                 isp_address, isp_data, e[41:32], e[31:0]);
                    end
                end
            end
            if (start) begin
                start_count++;
                n_checks++;
                if (prog_address !== 10'd0 || isp_write !== 1'b0) begin
                    n_errors++;
                    $display("FAIL start_cycle prog_address=%0d isp_write=%b want 0 0",
                             prog_address, isp_write);
                end
            end
        end
    end

    task automatic apply_reset();
        in_valid = 1'b0;
        in_data  = 8'h00;
        reset    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int waited;
        if (max_gap > 0) begin
            gap = int'($urandom_range(max_gap, 0));
            in_valid = 1'b0;
            repeat (gap) begin
                @(posedge clock);
                #1;
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clock);
            #1;
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL in_ready_timeout got in_ready=%b want 1", in_ready);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Sends a frame from frame_words; data_limit < 0 sends everything including CHK.
    task automatic send_frame(input int n, input logic [7:0] chk_flip, input int max_gap,
                              input int data_limit);
        logic [7:0]  chk;
        logic [7:0]  b;
        logic [15:0] cnt;
        logic [31:0] w32;
        int sent;
        cnt  = n[15:0];
        chk  = 8'h00;
        sent = 0;
        b = cnt[7:0];  send_byte(b, max_gap); chk ^= b;
        b = cnt[15:8]; send_byte(b, max_gap); chk ^= b;
        for (int w = 0; w < n; w++) begin
            w32 = frame_words[w];
            for (int k = 0; k < 4; k++) begin
                if (data_limit >= 0 && sent == data_limit) return;
                b = w32[8*k +: 8];
                if (k == 3) exp_q.push_back({w[9:0], w32});
                send_byte(b, max_gap);
                chk ^= b;
                sent++;
            end
        end
        send_byte(chk ^ chk_flip, max_gap);
    endtask

    task automatic load_two_words();
        frame_words[0] = 32'h12345678;
        frame_words[1] = 32'hDEADBEEF;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({in_ready, core_hold, isp_write, start, busy, done, error} !== 7'b1100000) begin
            n_errors++;
            $display("FAIL reset_flags got %b want 1100000",
                     {in_ready, core_hold, isp_write, start, busy, done, error});
        end
        n_checks++;
        if (words_loaded !== 11'd0 || isp_address !== 10'd0 || isp_data !== 32'd0 ||
            prog_address !== 10'd0) begin
            n_errors++;
            $display("FAIL reset_values got wl=%0d addr=%0d data=%h prog=%0d want 0 0 0 0",
                     words_loaded, isp_address, isp_data, prog_address);
        end
    endtask

    task automatic test_two_word(input int max_gap, input string name);
        int s0;
        apply_reset();
        load_two_words();
        s0 = start_count;
        send_frame(2, 8'h00, max_gap, -1);
        wait_cycles(3);
        n_checks++;
        if (words_loaded !== 11'd2 || done !== 1'b1 || core_hold !== 1'b0 || error !== 1'b0 ||
            busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_status got wl=%0d done=%b hold=%b err=%b busy=%b want 2 1 0 0 0",
                     name, words_loaded, done, core_hold, error, busy);
        end
        n_checks++;
        if (start_count - s0 !== 1 || exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL %s_starts got starts=%0d pending=%0d want 1 0",
                     name, start_count - s0, exp_q.size());
        end
    endtask

    task automatic test_bad_checksum();
        int s0;
        apply_reset();
        load_two_words();
        s0 = start_count;
        send_frame(2, 8'h01, 0, -1);
        wait_cycles(3);
        n_checks++;
        if (error !== 1'b1 || done !== 1'b0 || core_hold !== 1'b1 || busy !== 1'b0 ||
            words_loaded !== 11'd2) begin
            n_errors++;
            $display("FAIL bad_chk_status got err=%b done=%b hold=%b busy=%b wl=%0d want 1 0 1 0 2",
                     error, done, core_hold, busy, words_loaded);
        end
        n_checks++;
        if (start_count - s0 !== 0 || exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL bad_chk_starts got starts=%0d pending=%0d want 0 0",
                     start_count - s0, exp_q.size());
        end
    endtask

    task automatic test_zero_count();
        int s0;
        int w0;
        apply_reset();
        s0 = start_count;
        w0 = write_count;
        send_frame(0, 8'h00, 0, -1);
        wait_cycles(3);
        n_checks++;
        if (done !== 1'b1 || start_count - s0 !== 1 || write_count - w0 !== 0 ||
            words_loaded !== 11'd0) begin
            n_errors++;
            $display("FAIL zero_count got done=%b starts=%0d writes=%0d wl=%0d want 1 1 0 0",
                     done, start_count - s0, write_count - w0, words_loaded);
        end
    endtask

    task automatic test_oversize();
        int s0;
        int w0;
        apply_reset();
        s0 = start_count;
        w0 = write_count;
        send_byte(8'h01, 0);
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL oversize_busy got %b want 1", busy);
        end
        send_byte(8'h04, 0);
        n_checks++;
        if (error !== 1'b1 || busy !== 1'b0 || core_hold !== 1'b1) begin
            n_errors++;
            $display("FAIL oversize_error got err=%b busy=%b hold=%b want 1 0 1",
                     error, busy, core_hold);
        end
        // The next bytes open a fresh frame (N=1) that is left incomplete.
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        wait_cycles(3);
        n_checks++;
        if (write_count - w0 !== 0 || start_count - s0 !== 0 || error !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL oversize_after got writes=%0d starts=%0d err=%b busy=%b want 0 0 0 1",
                     write_count - w0, start_count - s0, error, busy);
        end
    endtask

    task automatic test_full_memory();
        int s0;
        int w0;
        apply_reset();
        for (int i = 0; i < 1024; i++) frame_words[i] = $urandom;
        s0 = start_count;
        w0 = write_count;
        send_frame(1024, 8'h00, 0, -1);
        wait_cycles(3);
        n_checks++;
        if (words_loaded !== 11'd1024 || done !== 1'b1 || start_count - s0 !== 1 ||
            write_count - w0 !== 1024 || exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL full_memory got wl=%0d done=%b starts=%0d writes=%0d pending=%0d want 1024 1 1 1024 0",
                     words_loaded, done, start_count - s0, write_count - w0, exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        int s0;
        int w0;
        apply_reset();
        load_two_words();
        w0 = write_count;
        send_frame(2, 8'h00, 0, 5);
        wait_cycles(1);
        apply_reset();
        wait_cycles(2);
        n_checks++;
        if (write_count - w0 !== 1 || exp_q.size() !== 0 || busy !== 1'b0 ||
            words_loaded !== 11'd0) begin
            n_errors++;
            $display("FAIL mid_reset_abort got writes=%0d pending=%0d busy=%b wl=%0d want 1 0 0 0",
                     write_count - w0, exp_q.size(), busy, words_loaded);
        end
        s0 = start_count;
        send_frame(2, 8'h00, 0, -1);
        wait_cycles(3);
        n_checks++;
        if (start_count - s0 !== 1 || write_count - w0 !== 3 || done !== 1'b1 ||
            words_loaded !== 11'd2) begin
            n_errors++;
            $display("FAIL mid_reset_reload got starts=%0d writes=%0d done=%b wl=%0d want 1 3 1 2",
                     start_count - s0, write_count - w0, done, words_loaded);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  chk;
        logic [7:0]  b;
        logic [31:0] w32;
        int s0;
        s0  = start_count;
        w32 = 32'hCAFEF00D;
        send_byte(8'h01, 0);
        n_checks++;
        if (core_hold !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_restart got hold=%b done=%b busy=%b want 1 0 1",
                     core_hold, done, busy);
        end
        chk = 8'h01;
        send_byte(8'h00, 0);
        for (int k = 0; k < 4; k++) begin
            b = w32[8*k +: 8];
            if (k == 3) exp_q.push_back({10'd0, w32});
            send_byte(b, 0);
            chk ^= b;
        end
        send_byte(chk, 0);
        wait_cycles(3);
        n_checks++;
        if (start_count - s0 !== 1 || done !== 1'b1 || words_loaded !== 11'd1 ||
            exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL b2b_done got starts=%0d done=%b wl=%0d pending=%0d want 1 1 1 0",
                     start_count - s0, done, words_loaded, exp_q.size());
        end
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_two_word(0, "two_word");
        test_back_to_back();
        test_bad_checksum();
        test_zero_count();
        test_oversize();
        test_two_word(3, "gappy");
        test_mid_reset();
        test_full_memory();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
